// File: rtl/complex_mac_pkg.sv
// rtl/complex_mac_pkg.sv - shared widths, complex sample type and saturate helper for complex_mac
package complex_mac_pkg;

  localparam int BITS_DEF    = 32;
  localparam int N_DEF       = BITS_DEF / 2;
  localparam int PROD_W_DEF  = 2 * N_DEF;
  localparam int MAX_LEN_DEF = 256;
  localparam int ACC_W_DEF   = PROD_W_DEF + 1 + $clog2(MAX_LEN_DEF);

  typedef struct packed {
    logic signed [N_DEF-1:0] re;
    logic signed [N_DEF-1:0] im;
  } complex_t;

  // Clamp a value to the n-bit signed range; the 64-bit carrier covers any sane accumulator width.
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] x, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/complex_mac_scale.sv
// rtl/complex_mac_scale.sv - shift by FRAC, optional round half up, saturate one component
// COMPLEX_MAC_ROUND_EN selects rounding; undefined gives floor.
import complex_mac_pkg::*;

module complex_mac_scale #(
  parameter int IN_W = 41,
  parameter int N    = 16,
  parameter int FRAC = 14
) (
  input  logic signed [IN_W-1:0] value,
  output logic signed [N-1:0]    result
);

  localparam int W = IN_W + 1;

  logic signed [W-1:0]  ext;
  logic signed [W-1:0]  biased;
  logic signed [W-1:0]  shifted;
  logic signed [63:0]   wide;

  // One extra bit keeps the rounding bias from overflowing the accumulator range.
  assign ext = {value[IN_W-1], value};

`ifdef COMPLEX_MAC_ROUND_EN
  assign biased = ext + ({{(W-1){1'b0}}, 1'b1} << (FRAC - 1));
`else
  assign biased = ext;
`endif

  assign shifted = biased >>> FRAC;
  assign wide    = {{(64-W){shifted[W-1]}}, shifted};
  assign result  = N'(sat_n(wide, N));

endmodule

// File: rtl/complex_mac.sv
// rtl/complex_mac.sv - streaming complex multiply-accumulate with per-sample conjugate
// Rounding of the frame result is enabled by COMPLEX_MAC_ROUND_EN.
import complex_mac_pkg::*;

module complex_mac #(
  parameter int BITS    = BITS_DEF,
  parameter int FRAC    = 14,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            conj,
  input  logic            last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c
);

  localparam int N  = BITS / 2;
  localparam int PW = 2 * N;
  localparam int SW = PW + 1;
  localparam int G  = $clog2(MAX_LEN);
  localparam int AW = SW + G;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Operands are widened to the product width so the multiply is exact.
  logic signed [PW-1:0] ar, ai, br, bi;
  assign ar = {{N{a[BITS-1]}}, a[BITS-1:N]};
  assign ai = {{N{a[N-1]}},    a[N-1:0]};
  assign br = {{N{b[BITS-1]}}, b[BITS-1:N]};
  assign bi = {{N{b[N-1]}},    b[N-1:0]};

  logic                 p1_v, p1_conj, p1_last;
  logic signed [PW-1:0] p1_rr, p1_ii, p1_ri, p1_ir;

  logic signed [SW-1:0] rr_x, ii_x, ri_x, ir_x;
  logic signed [SW-1:0] p2_re_d, p2_im_d;
  assign rr_x = {p1_rr[PW-1], p1_rr};
  assign ii_x = {p1_ii[PW-1], p1_ii};
  assign ri_x = {p1_ri[PW-1], p1_ri};
  assign ir_x = {p1_ir[PW-1], p1_ir};
  assign p2_re_d = p1_conj ? (rr_x + ii_x) : (rr_x - ii_x);
  assign p2_im_d = p1_conj ? (ir_x - ri_x) : (ri_x + ir_x);

  logic                 p2_v, p2_last;
  logic signed [SW-1:0] p2_re, p2_im;

  logic signed [AW-1:0] acc_re, acc_im;
  logic signed [AW-1:0] sum_re, sum_im;
  assign sum_re = acc_re + {{G{p2_re[SW-1]}}, p2_re};
  assign sum_im = acc_im + {{G{p2_im[SW-1]}}, p2_im};

  logic signed [N-1:0] c_re, c_im;

  complex_mac_scale #(.IN_W(AW), .N(N), .FRAC(FRAC)) u_scale_re (
    .value  (sum_re),
    .result (c_re)
  );

  complex_mac_scale #(.IN_W(AW), .N(N), .FRAC(FRAC)) u_scale_im (
    .value  (sum_im),
    .result (c_im)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_v      <= 1'b0;
      p1_conj   <= 1'b0;
      p1_last   <= 1'b0;
      p1_rr     <= '0;
      p1_ii     <= '0;
      p1_ri     <= '0;
      p1_ir     <= '0;
      p2_v      <= 1'b0;
      p2_last   <= 1'b0;
      p2_re     <= '0;
      p2_im     <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      p1_v      <= in_valid;
      p1_conj   <= conj;
      p1_last   <= last;
      p1_rr     <= ar * br;
      p1_ii     <= ai * bi;
      p1_ri     <= ar * bi;
      p1_ir     <= ai * br;
      p2_v      <= p1_v;
      p2_last   <= p1_last;
      p2_re     <= p2_re_d;
      p2_im     <= p2_im_d;
      // A consumed result drops out_valid unless a new frame ends on the same edge.
      out_valid <= p2_v && p2_last;
      if (p2_v) begin
        if (p2_last) begin
          c      <= {c_re, c_im};
          acc_re <= '0;
          acc_im <= '0;
        end else begin
          acc_re <= sum_re;
          acc_im <= sum_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_mac.sv
// tb/tb_complex_mac.sv - directed self-checking bench for complex_mac
module tb_complex_mac;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        conj;
  logic        last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  complex_mac #(.BITS(32), .FRAC(14), .MAX_LEN(256)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .conj      (conj),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vl);
    int n;
    a = va; b = vb; conj = vc; last = vl; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; conj = 1'b0; last = 1'b0;
  endtask

  task automatic wait_result(input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, c, exp);
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; a = '0; b = '0; conj = 1'b0; last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", c, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    // Single-sample frame: latency and one-cycle-wide out_valid
    send(32'h4000_0000, 32'h2000_2000, 1'b0, 1'b1);
    check("lat_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge3", 32'(out_valid), 32'd1);
    check("t1_c", c, 32'h2000_2000);
    @(negedge clk);
    check("t1_one_cycle", 32'(out_valid), 32'd0);

    // j*j and j*conj(j), then j*(1+j) both ways
    send(32'h0000_4000, 32'h0000_4000, 1'b0, 1'b1);
    wait_result(32'hC000_0000, "jj");
    send(32'h0000_4000, 32'h0000_4000, 1'b1, 1'b1);
    wait_result(32'h4000_0000, "jj_conj");
    send(32'h0000_4000, 32'h4000_4000, 1'b0, 1'b1);
    wait_result(32'hC000_4000, "j_1pj");
    send(32'h0000_4000, 32'h4000_4000, 1'b1, 1'b1);
    wait_result(32'h4000_4000, "j_1pj_conj");

    // Four-sample frame saturates positive, then acc must be clear
    for (int i = 0; i < 4; i++) send(32'h4000_0000, 32'h2000_0000, 1'b0, i == 3);
    wait_result(32'h7FFF_0000, "sat_pos");
    send(32'h4000_0000, 32'h2000_0000, 1'b0, 1'b1);
    wait_result(32'h2000_0000, "acc_cleared");

    // Negative product and negative saturation (-3.0)
    send(32'hC000_0000, 32'h2000_0000, 1'b0, 1'b1);
    wait_result(32'hE000_0000, "neg_half");
    for (int i = 0; i < 3; i++) send(32'hC000_0000, 32'h4000_0000, 1'b0, i == 2);
    wait_result(32'h8000_0000, "sat_neg");

    // Backpressure: two back-to-back frames with out_ready low
    out_ready = 1'b0;
    send(32'h4000_0000, 32'h1000_0000, 1'b0, 1'b1);
    send(32'h4000_0000, 32'h3000_0000, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_first_c", c, 32'h1000_0000);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_hold_c", c, 32'h1000_0000);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_c", c, 32'h3000_0000);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Half-LSB result: rounding selects between 1 and 0
    send(32'h0001_0000, 32'h2000_0000, 1'b0, 1'b1);
`ifdef COMPLEX_MAC_ROUND_EN
    wait_result(32'h0001_0000, "half_lsb");
`else
    wait_result(32'h0000_0000, "half_lsb");
`endif

    // Reset mid-frame discards the partial sum
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1);
    wait_result(32'h7FFF_0000, "pre_rst_frame");
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_c", c, 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(32'h4000_0000, 32'h1000_0000, 1'b0, 1'b1);
    wait_result(32'h1000_0000, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
